prog_clock_divider: RTL

//  Runtime-programmable clock divider / prescaler for the emulator timers.

---
 rtl/prog_clock_divider_if.sv | 48 ++++
 rtl/prog_clock_divider.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider_if.sv
// ---------------------------------------------------------------------------
// prog_clock_divider_if
//   Control and status bundle for the programmable clock divider.
//   The master (timer controller or bench) drives the control side and the
//   slave (the divider) drives the status side.
//
//   Control (master -> slave):
//     enable    count enable, low freezes the divider
//     mode      00 off, 01 square, 10 pulse, 11 one-shot
//     div_in    new divisor value
//     div_load  one-cycle strobe capturing div_in as the pending divisor
//     start     one-shot trigger
//   Status (slave -> master):
//     Qn_out    live count, 0..E-1
//     tick      terminal-count tick, high while Qn_out == E-1
//     clock     divided output clock
//     busy      divider is running
//     load_pend a captured divisor is still waiting to be applied
// ---------------------------------------------------------------------------
interface prog_clock_divider_if #(
  parameter int counterWidth = 16
);

  logic                    enable;
  logic [1:0]              mode;
  logic [counterWidth-1:0] div_in;
  logic                    div_load;
  logic                    start;

  logic [counterWidth-1:0] Qn_out;
  logic                    tick;
  logic                    clock;
  logic                    busy;
  logic                    load_pend;

  // The controlling side: drives the knobs, watches the status.
  modport master (
    output enable, mode, div_in, div_load, start,
    input  Qn_out, tick, clock, busy, load_pend
  );

  // The divider itself: reads the knobs, reports its status.
  modport slave (
    input  enable, mode, div_in, div_load, start,
    output Qn_out, tick, clock, busy, load_pend
  );

endinterface

// File: rtl/prog_clock_divider.sv
// ---------------------------------------------------------------------------
// prog_clock_divider
//   Runtime-programmable clock divider / prescaler for the emulator timers.
//   Divides clock50 by an active divisor E and produces a divided square
//   clock (or a one-cycle pulse), a terminal-count tick and the live count.
//   Modes: off, free-run square, free-run pulse, one-shot. A new divisor
//   is held pending and only takes effect at a count wrap, at one-shot
//   completion or while idle, so the output never shows a short phase.
//
//   Ports:
//     clock50  system clock, all logic on its rising edge
//     MR       synchronous active-high master reset, dominates everything
//     bus      prog_clock_divider_if slave modport (control in, status out)
//
//   Parameters:
//     counterWidth  width of the count and of divisors
//     resetDiv      active divisor after reset (values below 2 become 2)
// ---------------------------------------------------------------------------
module prog_clock_divider #(
  parameter int counterWidth = 16,
  parameter int resetDiv     = 2
) (
  input logic                  clock50,
  input logic                  MR,
  prog_clock_divider_if.slave  bus
);

  typedef logic [counterWidth-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_PULSE   = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam cnt_t MIN_DIV = cnt_t'(2);
  localparam cnt_t RESET_E = (resetDiv < 2) ? MIN_DIV : cnt_t'(resetDiv);

  state_t     state_q, state_d;
  cnt_t       count_q, count_d;
  logic       clk_q, clk_d;
  logic       tick_q, tick_d;
  cnt_t       div_q, div_d;
  cnt_t       pend_q, pend_d;
  logic       load_pend_q, load_pend_d;
  logic [1:0] mode_q, mode_d;

  logic                  last;
  cnt_t                  nxt;
  logic [counterWidth:0] half;
  logic                  in_high;
  logic                  nxt_is_last;
  logic                  start_ok;
  logic                  apply;

  // Shared arithmetic for the running count. The half-period is computed
  // one bit wider so that E = 2^counterWidth-1 cannot overflow the +1 in
  // ceil(E/2). E is never below 2, so E-1 never underflows.
  assign last        = (count_q == div_q - cnt_t'(1));
  assign nxt         = last ? '0 : count_q + cnt_t'(1);
  assign half        = ({1'b0, div_q} + (counterWidth + 1)'(1)) >> 1;
  assign in_high     = ({1'b0, nxt} < half);
  assign nxt_is_last = (nxt == div_q - cnt_t'(1));
  assign start_ok    = (bus.mode != MODE_OFF) &&
                       ((bus.mode != MODE_ONESHOT) || bus.start);

  // The pending divisor may only replace the active one where no phase
  // is in flight: at the wrap edge of a running count (which also covers
  // one-shot completion) or on any edge while idle.
  assign apply = load_pend_q &&
                 ((state_q == IDLE) || (bus.enable && last));

  // Next-state logic. Divisor bookkeeping runs independently of enable so
  // loads are never lost; a same-cycle load after an apply stays pending.
  // A mode change always drops back to IDLE, even with enable low.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    clk_d       = clk_q;
    tick_d      = tick_q;
    div_d       = div_q;
    pend_d      = pend_q;
    load_pend_d = load_pend_q;
    mode_d      = bus.mode;

    if (apply) begin
      div_d       = pend_q;
      load_pend_d = 1'b0;
    end
    if (bus.div_load) begin
      pend_d      = (bus.div_in < MIN_DIV) ? MIN_DIV : bus.div_in;
      load_pend_d = 1'b1;
    end

    if (bus.mode != mode_q) begin
      state_d = IDLE;
      count_d = '0;
      clk_d   = 1'b0;
      tick_d  = 1'b0;
    end else if (!bus.enable) begin
      tick_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          clk_d   = 1'b0;
          tick_d  = 1'b0;
          if (start_ok) begin
            state_d = RUN;
            clk_d   = (bus.mode != MODE_PULSE);
          end
        end
        RUN: begin
          if ((bus.mode == MODE_OFF) ||
              ((bus.mode == MODE_ONESHOT) && last)) begin
            state_d = IDLE;
            count_d = '0;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
          end else begin
            count_d = nxt;
            tick_d  = nxt_is_last;
            clk_d   = (bus.mode == MODE_PULSE) ? nxt_is_last : in_high;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          clk_d   = 1'b0;
          tick_d  = 1'b0;
        end
      endcase
    end
  end

  // State register. MR restores the reset divisor and discards any
  // pending load along with the rest of the state.
  always_ff @(posedge clock50) begin
    if (MR) begin
      state_q     <= IDLE;
      count_q     <= '0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
      div_q       <= RESET_E;
      pend_q      <= RESET_E;
      load_pend_q <= 1'b0;
      mode_q      <= MODE_OFF;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      load_pend_q <= load_pend_d;
      mode_q      <= mode_d;
    end
  end

  assign bus.Qn_out    = count_q;
  assign bus.tick      = tick_q;
  assign bus.clock     = clk_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.load_pend = load_pend_q;

endmodule
